// File: rtl/dmem_bus.sv
// dmem_bus: byte-addressable data memory with valid/ready request/response
// Ports: clk, rstn, req_{valid,ready,we,funct3,addr,wdata,pc}, resp_{valid,ready,rdata,fault}
module dmem_bus #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [1:0]  lane;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        legal;
  logic        oor;
  logic        misal;
  logic        fault;
  logic        sx;
  logic [3:0]  be;
  logic [31:0] ws;
  logic [31:0] cur;
  logic [31:0] upd;
  logic [31:0] sh;
  logic [31:0] ld;
  logic        acc;

  assign acc   = req_valid && req_ready;
  assign off   = req_addr - BASE_ADDR;
  assign idx   = off[AW+1:2];
  assign lane  = off[1:0];
  assign is_b  = (req_funct3[1:0] == 2'b00);
  assign is_h  = (req_funct3[1:0] == 2'b01);
  assign is_w  = (req_funct3 == 3'b010);
  assign legal = is_b || is_h || is_w;
  assign oor   = ({1'b0, off} >= LIMIT);
  assign misal = (is_h && off[0]) || (is_w && (off[1:0] != 2'b00));
  assign fault = !legal || misal || oor;
  assign sx    = !req_funct3[2];
  assign cur   = mem[idx];
  assign sh    = cur >> {lane, 3'b000};

  always_comb begin
    be = 4'b0000;
    ws = req_wdata;
    ld = 32'h0;
    unique case (1'b1)
      is_w: begin
        be = 4'b1111;
        ld = cur;
      end
      is_h: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        ws = {2{req_wdata[15:0]}};
        ld = {{16{sx & sh[15]}}, sh[15:0]};
      end
      is_b: begin
        be = 4'b0001 << lane;
        ws = {4{req_wdata[7:0]}};
        ld = {{24{sx & sh[7]}}, sh[7:0]};
      end
      default: ;
    endcase
    upd = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) upd[8*i +: 8] = ws[8*i +: 8];
    end
  end

  // Array is deliberately not reset; the write commits at acceptance
  always_ff @(posedge clk) begin
    if (acc && req_we && !fault) begin
      mem[idx] <= upd;
`ifndef SYNTHESIS
      $display("pc = %h: dataaddr = %h, memdata = %h",
               req_pc, {req_addr[31:2], 2'b00}, upd);
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      cnt        <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            resp_fault <= fault;
            resp_rdata <= (req_we || fault) ? 32'h0 : ld;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus.sv
// tb_dmem_bus: directed vectors for dmem_bus
// u0: 1024 words, no waits, base 0; u1: 16 words, 3 waits, base 8000_0000
module tb_dmem_bus;

  logic        clk = 1'b0;
  logic        rstn;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] pc;
  logic        v0, v1, rr0, rr1;
  logic        rdy0, rdy1, rv0, rv1, f0, f1;
  logic [31:0] rd0, rd1;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  dmem_bus #(
    .DEPTH_WORDS(1024),
    .WAIT_CYCLES(0),
    .BASE_ADDR(32'h0000_0000)
  ) u0 (
    .clk(clk), .rstn(rstn),
    .req_valid(v0), .req_ready(rdy0),
    .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wd), .req_pc(pc),
    .resp_valid(rv0), .resp_ready(rr0),
    .resp_rdata(rd0), .resp_fault(f0)
  );

  dmem_bus #(
    .DEPTH_WORDS(16),
    .WAIT_CYCLES(3),
    .BASE_ADDR(32'h8000_0000)
  ) u1 (
    .clk(clk), .rstn(rstn),
    .req_valid(v1), .req_ready(rdy1),
    .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wd), .req_pc(pc),
    .resp_valid(rv1), .resp_ready(rr1),
    .resp_rdata(rd1), .resp_fault(f1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic xact(input int sel, input logic w,
                      input logic [2:0] fn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ef,
                      input int el, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    chk({tag, " rdy"}, {31'b0, (sel == 0) ? rdy0 : rdy1}, 32'd1);
    we = w; f3 = fn; addr = a; wd = d; pc = pc + 32'd4;
    rr0 = 1'b1; rr1 = 1'b1;
    if (sel == 0) v0 = 1'b1;
    else v1 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0; v1 = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = (sel == 0) ? rv0 : rv1;
    end
    chk({tag, " lat"}, 32'(lat), 32'(el));
    chk({tag, " data"}, (sel == 0) ? rd0 : rd1, er);
    chk({tag, " flt"}, {31'b0, (sel == 0) ? f0 : f1}, {31'b0, ef});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    rstn = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b0; rr1 = 1'b0;
    we = 1'b0; f3 = 3'b0; addr = 32'h0; wd = 32'h0;
    pc = 32'h100;
    #1 rstn = 1'b0;
    #11;
    chk("rst rdy0", {31'b0, rdy0}, 32'd1);
    chk("rst rv0", {31'b0, rv0}, 32'd0);
    chk("rst rd0", rd0, 32'h0);
    chk("rst f0", {31'b0, f0}, 32'd0);
    chk("rst rdy1", {31'b0, rdy1}, 32'd1);
    chk("rst rv1", {31'b0, rv1}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    xact(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, "sw 10");
    xact(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, "lw 10");
    xact(0, 1, 3'b000, 32'h11, 32'h0000007F, 32'h0, 0, 1, "sb 11");
    xact(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 0, 1, "lw sb");
    xact(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 1, "lb 13");
    xact(0, 0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0, 1, "lbu 13");
    xact(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 1, "lh 12");
    xact(0, 0, 3'b101, 32'h10, 32'h0, 32'h00007FEF, 0, 1, "lhu 10");
    xact(0, 0, 3'b001, 32'h11, 32'h0, 32'h0, 1, 1, "lh 11");
    xact(0, 0, 3'b010, 32'h12, 32'h0, 32'h0, 1, 1, "lw 12");
    xact(0, 1, 3'b010, 32'h13, 32'h12345678, 32'h0, 1, 1, "sw 13");
    xact(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEAD7FEF, 0, 1, "lw keep");
    xact(0, 1, 3'b010, 32'h14, 32'h0, 32'h0, 0, 1, "sw 14");
    xact(0, 1, 3'b001, 32'h16, 32'h0000A5A5, 32'h0, 0, 1, "sh 16");
    xact(0, 0, 3'b010, 32'h14, 32'h0, 32'hA5A50000, 0, 1, "lw sh");
    xact(0, 0, 3'b000, 32'h17, 32'h0, 32'hFFFFFFA5, 0, 1, "lb 17");
    xact(0, 0, 3'b101, 32'h14, 32'h0, 32'h0, 0, 1, "lhu 14");
    xact(0, 1, 3'b010, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 1, "sw top");
    xact(0, 0, 3'b010, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 1, "lw top");
    xact(0, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 1, "lw oor");
    xact(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, "f3 011");
    xact(0, 0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 1, "f3 110");

    xact(1, 1, 3'b010, 32'h8000_0004, 32'h11223344, 32'h0, 0, 4, "w3 sw");
    xact(1, 0, 3'b001, 32'h8000_0006, 32'h0, 32'h00001122, 0, 4, "w3 lh");
    xact(1, 0, 3'b100, 32'h8000_0007, 32'h0, 32'h00000011, 0, 4, "w3 lbu");
    xact(1, 0, 3'b010, 32'h8000_0040, 32'h0, 32'h0, 1, 4, "w3 oor hi");
    xact(1, 0, 3'b010, 32'h7FFF_FFFC, 32'h0, 32'h0, 1, 4, "w3 oor lo");

    // stalled response
    @(negedge clk);
    we = 1'b0; f3 = 3'b010; addr = 32'h8000_0004;
    v1 = 1'b1; rr1 = 1'b0;
    @(posedge clk);
    #1 v1 = 1'b0;
    pulses = 0;
    while (!rv1 && pulses < 20) begin
      @(negedge clk);
      pulses++;
    end
    chk("stall lat", 32'(pulses), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall valid", {31'b0, rv1}, 32'd1);
      chk("stall data", rd1, 32'h11223344);
      chk("stall rdy", {31'b0, rdy1}, 32'd0);
    end
    rr1 = 1'b1;
    @(posedge clk);
    #1;
    chk("hs rdy", {31'b0, rdy1}, 32'd1);
    chk("hs valid", {31'b0, rv1}, 32'd0);

    // reset during WAIT after a store
    @(negedge clk);
    we = 1'b1; f3 = 3'b010; addr = 32'h8000_0008; wd = 32'h55AA55AA;
    v1 = 1'b1;
    @(posedge clk);
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("wait rdy", {31'b0, rdy1}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("arst rdy", {31'b0, rdy1}, 32'd1);
    chk("arst valid", {31'b0, rv1}, 32'd0);
    chk("arst data", rd1, 32'h0);
    chk("arst flt", {31'b0, f1}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv1) pulses++;
    end
    chk("no resp", 32'(pulses), 32'd0);
    xact(1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'h55AA55AA, 0, 4, "post rst lw");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
